// File: rtl/game_move_ctrl.sv
// -----------------------------------------------------------------------------
// game_move_ctrl
//
// 2048 board sequencer. Takes one-cycle direction pulses, slides and merges the
// 4x4 board one line per clock into a private work copy, spawns a new tile at
// an LFSR-chosen position, and copies the work board to the visible board only
// while the display is in vertical blanking.
//
// Ports:
//   CLK                    system clock
//   RST                    synchronous active-high reset
//   up, down, left, right  one-cycle debounced key pulses (up > down > left > right)
//   vnotactive             high during vertical blanking; gates the commit
//   load                   in IDLE, copy load_board into work and visible boards
//   load_board[63:0]       board image to load
//   board[63:0]            visible board, cell i = row*4+col at [4i+3:4i]
//   score[19:0]            visible score, saturating at 20'hFFFFF
//   won                    some visible cell holds exponent >= 11
//   busy                   sequencer is not in IDLE
//   moved                  one-cycle pulse on the commit edge
//
// Build option:
//   GAME_SPAWN_FOUR_EN  when defined, a spawned tile is exponent 2 if
//                       lfsr[15:13]==0 on the placement cycle, else 1.
// -----------------------------------------------------------------------------
module game_move_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        vnotactive,
  input  logic        load,
  input  logic [63:0] load_board,
  output logic [63:0] board,
  output logic [19:0] score,
  output logic        won,
  output logic        busy,
  output logic        moved
);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_MERGE, S_SPAWN, S_COMMIT} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  state_t      state;
  dir_t        dir;
  logic [1:0]  line;
  logic        changed;
  logic [63:0] work_board;
  logic [19:0] work_score;
  logic [15:0] lfsr;
  logic [3:0]  spawn_start;
  logic [3:0]  spawn_k;
  logic        spawn_again;   // INIT places two tiles back to back

  // Cell index of element j of line ln, where j=0 sits against the wall the
  // tiles slide towards. Cell index is {row, col}.
  function automatic logic [3:0] cell_idx(input dir_t d, input logic [1:0] ln,
                                          input logic [1:0] j);
    case (d)
      DIR_LEFT:  cell_idx = {ln, j};
      DIR_RIGHT: cell_idx = {ln, ~j};
      DIR_UP:    cell_idx = {j, ln};
      default:   cell_idx = {~j, ln};
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Single-line slide/merge of the line currently addressed by (dir, line).
  // ---------------------------------------------------------------------------
  logic [3:0]  cell_in  [4];
  logic [3:0]  compact  [4];
  logic [3:0]  cell_out [4];
  logic [2:0]  n_cells;
  logic [2:0]  rd;
  logic [1:0]  nxt;
  logic [20:0] line_gain;
  logic        line_changed;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it holding its old value and no latch is inferred.
  always_comb begin
    n_cells      = '0;
    rd           = '0;
    nxt          = '0;
    line_gain    = '0;
    line_changed = 1'b0;
    for (int j = 0; j < 4; j++) begin
      cell_in[j]  = work_board[{cell_idx(dir, line, 2'(j)), 2'b00} +: 4];
      compact[j]  = '0;
      cell_out[j] = '0;
    end
    // Squeeze out empties; n_cells never exceeds j here, so [1:0] is enough.
    for (int j = 0; j < 4; j++) begin
      if (cell_in[j] != 4'd0) begin
        compact[n_cells[1:0]] = cell_in[j];
        n_cells = n_cells + 3'd1;
      end
    end
    // Consuming both cells of a pair is what keeps a merged tile from merging
    // again in the same move.
    for (int w = 0; w < 4; w++) begin
      if (rd < n_cells) begin
        nxt = rd[1:0] + 2'd1;
        if ((rd + 3'd1 < n_cells) && (compact[rd[1:0]] == compact[nxt])) begin
          cell_out[w] = (compact[rd[1:0]] == 4'hF) ? 4'hF : compact[rd[1:0]] + 4'd1;
          line_gain   = line_gain + (21'd1 << ({1'b0, compact[rd[1:0]]} + 5'd1));
          rd          = rd + 3'd2;
        end else begin
          cell_out[w] = compact[rd[1:0]];
          rd          = rd + 3'd1;
        end
      end
      if (cell_out[w] != cell_in[w]) line_changed = 1'b1;
    end
  end

  // Worst case sum (0xFFFFF + 2*2^16) still fits in 21 bits.
  logic [20:0] score_sum;
  logic [19:0] score_next;
  assign score_sum  = {1'b0, work_score} + line_gain;
  assign score_next = score_sum[20] ? 20'hFFFFF : score_sum[19:0];

  // ---------------------------------------------------------------------------
  // Spawn probe.
  // ---------------------------------------------------------------------------
  logic [3:0] spawn_cell;
  logic       spawn_empty;
  logic [3:0] spawn_tile;
  assign spawn_cell  = spawn_start + spawn_k;   // wraps mod 16
  assign spawn_empty = (work_board[{spawn_cell, 2'b00} +: 4] == 4'd0);
`ifdef GAME_SPAWN_FOUR_EN
  assign spawn_tile  = (lfsr[15:13] == 3'b000) ? 4'd2 : 4'd1;
`else
  assign spawn_tile  = 4'd1;
`endif

  always_comb begin
    won = 1'b0;
    for (int i = 0; i < 16; i++)
      if (board[4*i +: 4] >= 4'd11) won = 1'b1;
  end

  assign busy = (state != S_IDLE);

  // ---------------------------------------------------------------------------
  // Sequencer.
  // ---------------------------------------------------------------------------
  // NOTE: state is updated only with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_INIT;
      dir         <= DIR_UP;
      line        <= '0;
      changed     <= 1'b0;
      // NOTE: the work board is a plain register bank, not a RAM, so it is
      // reset here; INIT relies on starting from an empty board.
      work_board  <= '0;
      work_score  <= '0;
      board       <= '0;
      score       <= '0;
      moved       <= 1'b0;
      lfsr        <= 16'hACE1;
      spawn_start <= '0;
      spawn_k     <= '0;
      spawn_again <= 1'b0;
    end else begin
      // Fibonacci x^16+x^14+x^13+x^11+1, shifting right.
      lfsr  <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      moved <= 1'b0;
      case (state)
        S_INIT: begin
          spawn_start <= lfsr[3:0];
          spawn_k     <= '0;
          spawn_again <= 1'b1;
          state       <= S_SPAWN;
        end
        S_IDLE: begin
          if (load) begin
            work_board <= load_board;
            board      <= load_board;
            work_score <= '0;
            score      <= '0;
          end else if (up || down || left || right) begin
            if (up)        dir <= DIR_UP;
            else if (down) dir <= DIR_DOWN;
            else if (left) dir <= DIR_LEFT;
            else           dir <= DIR_RIGHT;
            line    <= '0;
            changed <= 1'b0;
            state   <= S_MERGE;
          end
        end
        S_MERGE: begin
          for (int j = 0; j < 4; j++)
            work_board[{cell_idx(dir, line, 2'(j)), 2'b00} +: 4] <= cell_out[j];
          work_score <= score_next;
          changed    <= changed | line_changed;
          line       <= line + 2'd1;
          if (line == 2'd3) begin
            if (changed || line_changed) begin
              spawn_start <= lfsr[3:0];
              spawn_k     <= '0;
              state       <= S_SPAWN;
            end else begin
              work_score <= score;   // a no-op move never reaches the display
              state      <= S_IDLE;
            end
          end
        end
        S_SPAWN: begin
          if (spawn_empty || spawn_k == 4'd15) begin
            if (spawn_empty) work_board[{spawn_cell, 2'b00} +: 4] <= spawn_tile;
            if (spawn_again) begin
              spawn_again <= 1'b0;
              spawn_start <= lfsr[3:0];
              spawn_k     <= '0;
            end else begin
              state <= S_COMMIT;
            end
          end else begin
            spawn_k <= spawn_k + 4'd1;
          end
        end
        S_COMMIT: begin
          if (vnotactive) begin
            board <= work_board;
            score <= work_score;
            moved <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: doc/game_move_ctrl.md
# game_move_ctrl

Sequencer for the 2048 board state: accepts debounced direction pulses, slides and merges the 4x4 board one line per cycle, spawns a new tile from an LFSR, and publishes the new board to the renderer only during vertical blanking. Sits between the key debouncer and the display/renderer block, which reads `board`. It replaces ad-hoc board updates so that the visible board never changes mid-frame.

## Interface
- No parameters. Board geometry is fixed at 4x4, with 4-bit exponents.
- CLK  in  1  system clock; one clock domain.
- RST  in  1  synchronous, active-high reset.
- up, down, left, right  in  1 each  one-cycle debounced key pulses.
- vnotactive  in  1  high during vertical blanking.
- load  in  1  in IDLE, loads `load_board`.
- load_board  in  64  board image to load.
- board  out  64  visible board.
  - Cell i = row*4+col, held at bits [4i+3:4i].
  - Value 0 means empty; value e means tile 2^e.
- score  out  20  visible score; saturates at 20'hFFFFF.
- won  out  1  high when any visible cell is >= 11.
- busy  out  1  high in every state except IDLE.
- moved  out  1  one-cycle pulse on the commit edge.

## Operation
- Internal state: work board, work score, 16-bit LFSR.
- LFSR:
  - Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Seed 16'hACE1 on reset; advances every cycle.
- States: INIT, IDLE, MERGE, SPAWN, COMMIT.
- INIT (entered on reset): runs SPAWN twice on the cleared board, then goes to COMMIT.
- IDLE:
  - `load` has priority over keys. It copies `load_board` into both work and visible boards, clears both scores, and stays in IDLE.
  - Key priority when several pulses coincide: up > down > left > right. Latch the direction, set line=0, go to MERGE.
  - Key pulses outside IDLE are dropped, not queued.
- MERGE: processes one line per cycle, line 0..3.
  - Extract cells c0..c3, where c0 is the cell against the destination wall:
    - left: (r,0..3)
    - right: (r,3..0)
    - up: (0..3,c)
    - down: (3..0,c)
  - Compact out the empty cells.
  - Scan from c0 and merge equal adjacent pairs. The result is e+1, saturating at 15. A merged cell does not merge again in the same move.
  - Fill the remainder with 0 and write the line back.
  - Each merge adds 2^(e+1) to the work score, saturating.
  - A sticky `changed` flag is set if any cell differs.
  - After line 3:
    - If `changed`, go to SPAWN.
    - Otherwise go to IDLE. No commit, no `moved` pulse, and the work score is restored to the visible score.
- SPAWN:
  - Latch start = lfsr[3:0], k=0.
  - Each cycle, test cell (start+k) mod 16. On the first empty cell, write the tile and go to the next state. Otherwise k++.
  - If k reaches 16 with no empty cell, place no tile.
  - Tile exponent is 1; see Configuration for the exception.
- COMMIT:
  - Waits for vnotactive=1.
  - On that edge: board <= work board, score <= work score, moved pulses, then IDLE.
- `won` is combinational from the visible board.

## Timing
- Reset values: board=0, score=0, moved=0, won=0, busy=1 (state INIT). LFSR = 16'hACE1.
- RST overrides every state, including mid-MERGE or mid-SPAWN. Partial work is discarded.
- Key pulse sampled in IDLE at edge T:
  - MERGE runs on edges T+1..T+4.
  - SPAWN tests its first cell at T+5 and takes k+1 cycles.
  - COMMIT takes effect at the first edge where vnotactive=1.
- No-change move: busy is high for exactly 4 cycles.
- Load in IDLE: board and score update at the next edge; busy stays 0.
- The visible board changes only on a commit edge or a load edge.

## Configuration
- `GAME_SPAWN_FOUR_EN` defined: the spawned exponent is 2 (tile 4) when lfsr[15:13]==3'b000 on the placement cycle; otherwise it is 1.
- Undefined: every spawned tile has exponent 1.
- Everything else is identical in both builds.

## Test plan
- Reset with vnotactive=1 (macro undefined):
  - Within 40 cycles, busy falls.
  - Exactly two cells equal 1, all others 0.
  - score=0 and moved pulsed once.
- Load row0=[1,1,1,1], rest 0, then pulse left:
  - Row0 holds [2,2] in cols 0-1.
  - Exactly one new cell of value 1 appears in some empty cell.
  - score=8.
- Load row0=[1,1,2,0], then pulse left:
  - Row0 cols 0-1 = [2,2]; the new 2 does not re-merge.
  - score=4.
- Load cell 12=1 only, then pulse down:
  - busy high for 4 cycles; no moved pulse.
  - board and score unchanged.
- Load cells 0,1 = 10,10, hold vnotactive=0, then pulse up and left together:
  - Up is executed, so there is no change and the sequencer returns to IDLE.
- Pulse left on the same board with vnotactive=0:
  - board is unchanged until vnotactive rises.
  - On the next edge: cell0=11, won=1, score=2048.
